// File: rtl/ifu_fetch_ctrl.sv
// rvseed instruction fetch unit: PC owner, in-order fetch issue,
// instruction buffer and redirect flush with stale-response drop.
//
// Ports:
//   clk, rst_n          clock / async active-low reset
//   imem_req_*          fetch request (vld/rdy/addr)
//   imem_rsp_*          in-order response (vld/data), always accepted
//   ifu2idu_*           buffer head to IDU (en/pc/inst)
//   idu2ifu_stall       IDU holds the head
//   exu2ifu_*           branch/jump redirect and target
//   ifu_misalign_err    sticky misaligned-target error
//
// Optional feature macro: IFU_MISALIGN_CHK_EN (misaligned target
// sets a sticky error and halts fetch; otherwise target[1:0] is forced 0).

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module ifu_fetch_ctrl #(
  parameter logic [`CPU_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_vld,
  input  logic                  imem_req_rdy,
  output logic [`CPU_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_vld,
  input  logic [`CPU_WIDTH-1:0] imem_rsp_data,
  output logic                  ifu2idu_en,
  output logic [`CPU_WIDTH-1:0] ifu2idu_pc,
  output logic [`CPU_WIDTH-1:0] ifu2idu_inst,
  input  logic                  idu2ifu_stall,
  input  logic                  exu2ifu_branch_en,
  input  logic                  exu2ifu_jump_en,
  input  logic [`CPU_WIDTH-1:0] exu2ifu_target,
  output logic                  ifu_misalign_err
);

  localparam int W  = `CPU_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  pc_q, pc_d;
  logic [W-1:0]  fpc_q   [FIFO_DEPTH];
  logic [W-1:0]  finst_q [FIFO_DEPTH];
  logic [W-1:0]  ppc_q   [FIFO_DEPTH];
  logic [AW-1:0] fwr_q, fwr_d, frd_q, frd_d;
  logic [AW-1:0] pwr_q, pwr_d, prd_q, prd_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;

  logic          redirect;
  logic [W-1:0]  tgt;
  logic          halted;
  logic [CW+1:0] used;
  logic          credit;
  logic          hs;
  logic          rsp_keep;
  logic          pop;

  assign redirect = exu2ifu_branch_en | exu2ifu_jump_en;

`ifdef IFU_MISALIGN_CHK_EN
  logic halt_q, halt_d;
  logic err_q, err_d;
  logic mis;

  assign tgt    = exu2ifu_target;
  assign mis    = |exu2ifu_target[1:0];
  assign halted = halt_q;
  assign ifu_misalign_err = err_q;

  always_comb begin
    halt_d = halt_q;
    err_d  = err_q;
    if (redirect && mis) begin
      halt_d = 1'b1;
      err_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      halt_q <= halt_d;
      err_q  <= err_d;
    end
  end
`else
  logic unused_tgt_lsb;

  assign unused_tgt_lsb   = ^exu2ifu_target[1:0];
  assign tgt              = {exu2ifu_target[W-1:2], 2'b00};
  assign halted           = 1'b0;
  assign ifu_misalign_err = 1'b0;
`endif

  // Every slot is reserved from request until pop or drop,
  // so the buffer can never overflow.
  assign used   = {2'b00, out_q}
                + {2'b00, drop_q}
                + {2'b00, fcnt_q};
  assign credit = used < (CW+2)'(FIFO_DEPTH);

  assign imem_req_vld  = rst_n & ~redirect
                       & ~halted & credit;
  assign imem_req_addr = pc_q;

  assign hs       = imem_req_vld & imem_req_rdy;
  assign rsp_keep = imem_rsp_vld & ~redirect
                  & (drop_q == '0);

  assign ifu2idu_en   = fcnt_q != '0;
  assign ifu2idu_pc   = fpc_q[frd_q];
  assign ifu2idu_inst = finst_q[frd_q];

  assign pop = ifu2idu_en & ~idu2ifu_stall;

  always_comb begin
    pc_d   = pc_q;
    fwr_d  = fwr_q;
    frd_d  = frd_q;
    pwr_d  = pwr_q;
    prd_d  = prd_q;
    fcnt_d = fcnt_q;
    out_d  = out_q;
    drop_d = drop_q;
    if (redirect) begin
      pc_d   = tgt;
      fwr_d  = '0;
      frd_d  = '0;
      pwr_d  = '0;
      prd_d  = '0;
      fcnt_d = '0;
      out_d  = '0;
      // A response this cycle retires either a dropped
      // or an outstanding request; both are now stale.
      drop_d = drop_q + out_q
             - CW'(imem_rsp_vld);
    end else begin
      if (hs) begin
        pc_d  = pc_q + W'(4);
        pwr_d = pwr_q + 1'b1;
      end
      if (imem_rsp_vld) begin
        if (drop_q != '0) begin
          drop_d = drop_q - 1'b1;
        end else begin
          fwr_d = fwr_q + 1'b1;
          prd_d = prd_q + 1'b1;
        end
      end
      if (pop) begin
        frd_d = frd_q + 1'b1;
      end
      out_d  = out_q + CW'(hs)
             - CW'(rsp_keep);
      fcnt_d = fcnt_q + CW'(rsp_keep)
             - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      fwr_q  <= '0;
      frd_q  <= '0;
      pwr_q  <= '0;
      prd_q  <= '0;
      fcnt_q <= '0;
      out_q  <= '0;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      fwr_q  <= fwr_d;
      frd_q  <= frd_d;
      pwr_q  <= pwr_d;
      prd_q  <= prd_d;
      fcnt_q <= fcnt_d;
      out_q  <= out_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fpc_q[i]   <= '0;
        finst_q[i] <= '0;
        ppc_q[i]   <= '0;
      end
    end else begin
      if (hs) begin
        ppc_q[pwr_q] <= pc_q;
      end
      if (rsp_keep) begin
        fpc_q[fwr_q]   <= ppc_q[prd_q];
        finst_q[fwr_q] <= imem_rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed + randomized bench for ifu_fetch_ctrl with an in-order
// memory model and a delivered-PC scoreboard.

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module tb_ifu_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_vld;
  logic        imem_req_rdy = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_vld = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        ifu2idu_en;
  logic [31:0] ifu2idu_pc;
  logic [31:0] ifu2idu_inst;
  logic        idu2ifu_stall = 1'b0;
  logic        exu2ifu_branch_en = 1'b0;
  logic        exu2ifu_jump_en = 1'b0;
  logic [31:0] exu2ifu_target = '0;
  logic        ifu_misalign_err;

  int nvec = 0;
  int nerr = 0;

  logic        hold = 1'b0;
  logic        hs_pend = 1'b0;
  logic [31:0] hs_addr = '0;
  logic [31:0] mq[$];
  logic [31:0] expq[$];
  logic [31:0] model_pc = '0;

  ifu_fetch_ctrl #(
    .RESET_PC   (32'h0),
    .FIFO_DEPTH (4)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .imem_req_vld      (imem_req_vld),
    .imem_req_rdy      (imem_req_rdy),
    .imem_req_addr     (imem_req_addr),
    .imem_rsp_vld      (imem_rsp_vld),
    .imem_rsp_data     (imem_rsp_data),
    .ifu2idu_en        (ifu2idu_en),
    .ifu2idu_pc        (ifu2idu_pc),
    .ifu2idu_inst      (ifu2idu_inst),
    .idu2ifu_stall     (idu2ifu_stall),
    .exu2ifu_branch_en (exu2ifu_branch_en),
    .exu2ifu_jump_en   (exu2ifu_jump_en),
    .exu2ifu_target    (exu2ifu_target),
    .ifu_misalign_err  (ifu_misalign_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(
    input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // Memory: accepts on handshake, answers in order one
  // cycle later unless held.
  always @(negedge clk) begin
    hs_pend = rst_n & imem_req_vld & imem_req_rdy;
    hs_addr = imem_req_addr;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
    end else if (hs_pend) begin
      mq.push_back(hs_addr);
    end
    #1;
    if (rst_n && !hold && mq.size() > 0) begin
      imem_rsp_data = inst_of(mq[0]);
      void'(mq.pop_front());
      imem_rsp_vld = 1'b1;
    end else begin
      imem_rsp_vld = 1'b0;
    end
  end

  // Scoreboard: expected PCs pushed at request handshake,
  // popped at consume; a redirect kills everything older.
  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      model_pc = 32'h0;
    end else if (exu2ifu_branch_en || exu2ifu_jump_en) begin
      chk("rdir_no_req", {31'b0, imem_req_vld}, 32'h0);
      expq.delete();
`ifdef IFU_MISALIGN_CHK_EN
      model_pc = exu2ifu_target;
`else
      model_pc = exu2ifu_target & 32'hFFFF_FFFC;
`endif
    end else begin
      if (ifu2idu_en && !idu2ifu_stall) begin
        if (expq.size() == 0) begin
          nvec++;
          nerr++;
          $error("FAIL pop_unexpected: observed pc %h expected none",
                 ifu2idu_pc);
        end else begin
          chk("pop_pc", ifu2idu_pc, expq[0]);
          chk("pop_inst", ifu2idu_inst, inst_of(expq[0]));
          void'(expq.pop_front());
        end
      end
      if (imem_req_vld && imem_req_rdy) begin
        chk("req_addr", imem_req_addr, model_pc);
        expq.push_back(model_pc);
        model_pc = model_pc + 32'd4;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_pop(input string tag,
                          input logic [31:0] exp);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ifu2idu_en && !idu2ifu_stall) begin
        chk(tag, ifu2idu_pc, exp);
        return;
      end
    end
    nvec++;
    nerr++;
    $error("FAIL %s: observed no delivery expected pc %h",
           tag, exp);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_vld", {31'b0, imem_req_vld}, 32'h0);
    chk("rst_en", {31'b0, ifu2idu_en}, 32'h0);
    chk("rst_pc", ifu2idu_pc, 32'h0);
    chk("rst_inst", ifu2idu_inst, 32'h0);
    chk("rst_err", {31'b0, ifu_misalign_err}, 32'h0);

    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_vld", {31'b0, imem_req_vld}, 32'h1);
    chk("first_addr", imem_req_addr, 32'h0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      chk("stream_en", {31'b0, ifu2idu_en}, 32'h1);
      @(negedge clk);
    end

    step();
    idu2ifu_stall = 1'b1;
    repeat (10) @(negedge clk);
    chk("stall_vld", {31'b0, imem_req_vld}, 32'h0);
    chk("stall_en", {31'b0, ifu2idu_en}, 32'h1);
    chk("stall_buffered", expq.size(), 32'd4);
    step();
    idu2ifu_stall = 1'b0;
    repeat (8) step();

    hold = 1'b1;
    repeat (6) step();
    exu2ifu_jump_en = 1'b1;
    exu2ifu_target  = 32'h100;
    step();
    exu2ifu_jump_en = 1'b0;
    hold = 1'b0;
    wait_pop("jump_first_pc", 32'h100);
    repeat (4) step();

    idu2ifu_stall = 1'b1;
    hold = 1'b1;
    repeat (3) step();
    hold = 1'b0;
    step();
    exu2ifu_jump_en = 1'b1;
    exu2ifu_target  = 32'h180;
    step();
    exu2ifu_jump_en = 1'b0;
    @(negedge clk);
    chk("rdir_rsp_en", {31'b0, ifu2idu_en}, 32'h0);
    chk("rdir_rsp_vld", {31'b0, imem_req_vld}, 32'h1);
    step();
    idu2ifu_stall = 1'b0;
    wait_pop("rdir_rsp_first", 32'h180);

    step();
    exu2ifu_branch_en = 1'b1;
    exu2ifu_target    = 32'h200;
    step();
    exu2ifu_branch_en = 1'b0;
    exu2ifu_jump_en   = 1'b1;
    exu2ifu_target    = 32'h300;
    step();
    exu2ifu_jump_en = 1'b0;
    wait_pop("br_jmp_first", 32'h300);

    for (int i = 0; i < 60; i++) begin
      step();
      imem_req_rdy  = ($urandom % 4) != 0;
      hold          = ($urandom % 3) == 0;
      idu2ifu_stall = ($urandom % 3) == 0;
      exu2ifu_jump_en = ($urandom % 10) == 0;
      exu2ifu_target  = {16'h0, 6'h0,
                         10'($urandom), 2'b00} | 32'h400;
    end
    step();
    exu2ifu_jump_en = 1'b0;
    imem_req_rdy    = 1'b1;
    hold            = 1'b0;
    idu2ifu_stall   = 1'b0;
    repeat (15) step();

    exu2ifu_jump_en = 1'b1;
    exu2ifu_target  = 32'h102;
    step();
    exu2ifu_jump_en = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
    @(negedge clk);
    chk("mis_err", {31'b0, ifu_misalign_err}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      chk("mis_halt_vld", {31'b0, imem_req_vld}, 32'h0);
      @(negedge clk);
    end
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mis_rst_err", {31'b0, ifu_misalign_err}, 32'h0);
    step();
    rst_n = 1'b1;
    wait_pop("mis_rst_first", 32'h0);
`else
    @(negedge clk);
    chk("mis_err_off", {31'b0, ifu_misalign_err}, 32'h0);
    wait_pop("mis_forced_pc", 32'h100);
`endif
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
